// File: rtl/key_enc_pkg.sv
// Shared types and constants for the 8-to-3 keypad encoder.
// The key sample struct pairs "any key active" with the priority code.
package key_enc_pkg;

  localparam int KEY_N      = 8;
  localparam int KEY_CODE_W = 3;

  // Inverted-code value shown when disabled or when no key is active.
  localparam logic [KEY_CODE_W-1:0] A_N_IDLE = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } key_enc_state_t;

  typedef struct packed {
    logic                  any;
    logic [KEY_CODE_W-1:0] code;
  } key_sample_t;

  // Highest-index low key wins; code is 0 when no key line is low.
  function automatic key_sample_t encode_keys(input logic [KEY_N-1:0] keys_n,
                                              input logic             en_n);
    key_sample_t s;
    s.any  = ~en_n & ~(&keys_n);
    s.code = '0;
    for (int i = 0; i < KEY_N; i++) begin
      if (!keys_n[i]) s.code = KEY_CODE_W'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Counter-based debouncer: accepts a new value after it has been seen
// unchanged for DEBOUNCE_CYCLES consecutive clocks.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DATA_W          = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] stable_o,
  output logic [DATA_W-1:0] stable_nxt_o,
  output logic              upd_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              match;
  logic              upd;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    prev_d   = data_i;
    match    = (data_i == prev_q);
    cnt_d    = cnt_q;
    upd      = 1'b0;
    if (!match) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
      upd   = (cnt_q == CNT_LOAD);
    end
    stable_d = upd ? data_i : stable_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= prev_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o     = stable_q;
  assign stable_nxt_o = stable_d;
  assign upd_o        = upd;

endmodule

// File: rtl/key_encoder83.sv
// Sequential 8-to-3 keypad priority encoder with 74148-style outputs and a
// valid/ready press-event port. Release events need KEY_ENC_RELEASE_EVT_EN.
module key_encoder83
  import key_enc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEY_N-1:0]      I_n,
  input  logic                  EI_n,
  output logic [KEY_CODE_W-1:0] A_n,
  output logic                  GS_n,
  output logic                  EO_n,
  output logic [KEY_CODE_W-1:0] code_o,
  output logic                  rel_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o
);

  logic [KEY_N-1:0] i_meta_q, i_meta_d, i_sync_q, i_sync_d;
  logic             ei_meta_q, ei_meta_d, ei_sync_q, ei_sync_d;

  always_comb begin
    i_meta_d  = I_n;
    i_sync_d  = i_meta_q;
    ei_meta_d = EI_n;
    ei_sync_d = ei_meta_q;
  end

  // Synchronisers reset to the idle (released, disabled) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_meta_q  <= '1;
      i_sync_q  <= '1;
      ei_meta_q <= 1'b1;
      ei_sync_q <= 1'b1;
    end else begin
      i_meta_q  <= i_meta_d;
      i_sync_q  <= i_sync_d;
      ei_meta_q <= ei_meta_d;
      ei_sync_q <= ei_sync_d;
    end
  end

  key_sample_t raw, stable_cur, stable_nxt;
  logic        upd;

  assign raw = encode_keys(i_sync_q, ei_sync_q);

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DATA_W          ($bits(key_sample_t))
  ) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (raw),
    .stable_o     (stable_cur),
    .stable_nxt_o (stable_nxt),
    .upd_o        (upd)
  );

  key_enc_state_t        state_q, state_d;
  logic                  chg;
  logic                  ev;
  logic [KEY_CODE_W-1:0] ev_code;
`ifdef KEY_ENC_RELEASE_EVT_EN
  logic                  ev_rel;
`endif

  // A reload of an identical value is not a change and raises nothing.
  assign chg = upd && (stable_nxt != stable_cur);

  always_comb begin
    state_d = state_q;
    ev      = 1'b0;
    ev_code = stable_nxt.code;
`ifdef KEY_ENC_RELEASE_EVT_EN
    ev_rel  = 1'b0;
`endif
    if (chg) begin
      case (state_q)
        IDLE: begin
          if (stable_nxt.any) begin
            ev      = 1'b1;
            state_d = HELD;
          end
        end
        HELD: begin
          if (!stable_nxt.any) begin
            state_d = IDLE;
`ifdef KEY_ENC_RELEASE_EVT_EN
            ev      = 1'b1;
            ev_code = stable_cur.code;
            ev_rel  = 1'b1;
`endif
          end else begin
            ev = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic [KEY_CODE_W-1:0] a_n_q, a_n_d;
  logic                  gs_n_q, gs_n_d, eo_n_q, eo_n_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;
  logic                  valid_q, valid_d, overrun_q, overrun_d;
  logic                  en;

  always_comb begin
    en     = ~ei_sync_q;
    a_n_d  = (en && stable_nxt.any) ? ~stable_nxt.code : A_N_IDLE;
    gs_n_d = ~(en && stable_nxt.any);
    eo_n_d = ~(en && !stable_nxt.any);

    valid_d   = valid_q;
    code_d    = code_q;
    overrun_d = 1'b0;
    if (valid_q && ready_i) valid_d = 1'b0;
    // A new event wins over a same-cycle consume; it only overruns an unread one.
    if (ev) begin
      valid_d   = 1'b1;
      code_d    = ev_code;
      overrun_d = valid_q && !ready_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_n_q     <= A_N_IDLE;
      gs_n_q    <= 1'b1;
      eo_n_q    <= 1'b1;
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_n_q     <= a_n_d;
      gs_n_q    <= gs_n_d;
      eo_n_q    <= eo_n_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef KEY_ENC_RELEASE_EVT_EN
  logic rel_q, rel_d;

  always_comb begin
    rel_d = rel_q;
    if (ev) rel_d = ev_rel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel_q <= 1'b0;
    else        rel_q <= rel_d;
  end

  assign rel_o = rel_q;
`else
  assign rel_o = 1'b0;
`endif

  assign A_n       = a_n_q;
  assign GS_n      = gs_n_q;
  assign EO_n      = eo_n_q;
  assign code_o    = code_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_key_encoder83.sv
// Self-checking bench for key_encoder83 (DEBOUNCE_CYCLES=4): directed cases
// with literal expectations plus random stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_key_encoder83;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] I_n = 8'hFF;
  logic       EI_n = 1'b1;
  logic       ready_i = 1'b0;
  logic [2:0] A_n, code_o;
  logic       GS_n, EO_n, rel_o, valid_o, overrun_o;

  key_encoder83 #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .I_n       (I_n),
    .EI_n      (EI_n),
    .A_n       (A_n),
    .GS_n      (GS_n),
    .EO_n      (EO_n),
    .code_o    (code_o),
    .rel_o     (rel_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic [7:0] cap_i   = 8'hFF;
  logic       cap_ei  = 1'b1;
  logic       cap_rdy = 1'b0;
  logic       cap_rst = 1'b0;

  always @(posedge clk) begin
    cap_i   <= I_n;
    cap_ei  <= EI_n;
    cap_rdy <= ready_i;
    cap_rst <= rst_n;
  end

  // Sample value: 8 + key index when a key counts as pressed, else the bare index.
  function automatic int enc(input logic [7:0] keys_n, input logic ei_n);
    int code;
    code = 0;
    for (int b = 7; b >= 0; b--) begin
      if (!keys_n[b]) begin
        code = b;
        break;
      end
    end
    return ((!ei_n && keys_n != 8'hFF) ? 8 : 0) + code;
  endfunction

  // Model: inputs reach the debouncer two clocks late; a value is accepted
  // once it has been seen DEB times in a row; events come from accepted changes.
  logic [8:0] dly[$];
  int m_last, m_run, m_stable, m_code, m_a;
  bit m_valid, m_rel, m_ovr, m_gs, m_eo;

  task automatic model_reset();
    dly.delete();
    dly.push_back({1'b1, 8'hFF});
    dly.push_back({1'b1, 8'hFF});
    m_last = 0; m_run = 1; m_stable = 0;
    m_valid = 0; m_rel = 0; m_ovr = 0; m_code = 0;
    m_a = 7; m_gs = 1; m_eo = 1;
  endtask

  task automatic model_step();
    logic [8:0] seen;
    int r, old, ev_code;
    bit ev, ev_rel, was_valid, en, any;
    seen = dly.pop_front();
    dly.push_back({cap_ei, cap_i});
    r = enc(seen[7:0], seen[8]);
    if (r == m_last) m_run++;
    else m_run = 1;
    m_last = r;
    ev = 0; ev_rel = 0; ev_code = 0;
    old = m_stable;
    if (m_run == DEB) begin
      m_stable = r;
      if (r >= 8 && r != old) begin
        ev = 1; ev_code = r - 8;
      end
`ifdef KEY_ENC_RELEASE_EVT_EN
      if (r < 8 && old >= 8) begin
        ev = 1; ev_code = old - 8; ev_rel = 1;
      end
`endif
    end
    was_valid = m_valid;
    m_ovr = 0;
    if (was_valid && cap_rdy) m_valid = 0;
    if (ev) begin
      m_ovr = was_valid && !cap_rdy;
      m_valid = 1; m_code = ev_code; m_rel = ev_rel;
    end
    en  = !seen[8];
    any = (m_stable >= 8);
    m_a  = (en && any) ? 7 - (m_stable - 8) : 7;
    m_gs = !(en && any);
    m_eo = !(en && !any);
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n || !cap_rst) model_reset();
      else model_step();
      check("A_n",       8'(A_n),       8'(m_a));
      check("GS_n",      8'(GS_n),      8'(m_gs));
      check("EO_n",      8'(EO_n),      8'(m_eo));
      check("valid_o",   8'(valid_o),   8'(m_valid));
      check("code_o",    8'(code_o),    8'(m_code));
      check("rel_o",     8'(rel_o),     8'(m_rel));
      check("overrun_o", 8'(overrun_o), 8'(m_ovr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
  endtask

  initial begin
    EI_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(8);
    check("idle A_n", 8'(A_n), 8'h07);
    check("idle GS_n", 8'(GS_n), 8'h01);
    check("idle EO_n", 8'(EO_n), 8'h00);
    check("idle valid", 8'(valid_o), 8'h00);

    // Key 2 press, held with the consumer stalled.
    I_n = 8'hFB;
    tick(5);
    check("k2 early valid", 8'(valid_o), 8'h00);
    tick(1);
    check("k2 valid", 8'(valid_o), 8'h01);
    check("k2 code", 8'(code_o), 8'h02);
    check("k2 A_n", 8'(A_n), 8'h05);
    check("k2 GS_n", 8'(GS_n), 8'h00);
    tick(4);
    check("k2 hold valid", 8'(valid_o), 8'h01);
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    check("k2 consumed", 8'(valid_o), 8'h00);

    // Keys 7 and 2 together: 7 wins.
    I_n = 8'h7B;
    tick(6);
    check("k7 valid", 8'(valid_o), 8'h01);
    check("k7 code", 8'(code_o), 8'h07);
    check("k7 A_n", 8'(A_n), 8'h00);
    drain();
    I_n = 8'hFF;
    tick(8);
    drain();

    // Bounce on key 2, then a clean hold.
    for (int k = 0; k < 6; k++) begin
      I_n = (k % 2 == 0) ? 8'hFB : 8'hFF;
      tick(2);
    end
    check("bounce no event", 8'(valid_o), 8'h00);
    I_n = 8'hFB;
    tick(5);
    check("bounce late valid", 8'(valid_o), 8'h00);
    tick(1);
    check("bounce valid", 8'(valid_o), 8'h01);
    check("bounce code", 8'(code_o), 8'h02);
    drain();
    I_n = 8'hFF;
    tick(8);
    drain();

    // Overrun: key 3 pending, key 5 added while stalled.
    I_n = 8'hF7;
    tick(6);
    check("k3 code", 8'(code_o), 8'h03);
    I_n = 8'hD7;
    tick(5);
    check("k3 still", 8'(code_o), 8'h03);
    check("no overrun yet", 8'(overrun_o), 8'h00);
    tick(1);
    check("k5 code", 8'(code_o), 8'h05);
    check("overrun pulse", 8'(overrun_o), 8'h01);
    check("overrun valid", 8'(valid_o), 8'h01);
    tick(1);
    check("overrun one clk", 8'(overrun_o), 8'h00);
    check("overrun code hold", 8'(code_o), 8'h05);
    drain();

    // Asynchronous reset with an event pending on key 1.
    I_n = 8'hFD;
    tick(6);
    check("k1 pending", 8'(valid_o), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst A_n", 8'(A_n), 8'h07);
    check("rst GS_n", 8'(GS_n), 8'h01);
    check("rst EO_n", 8'(EO_n), 8'h01);
    check("rst code", 8'(code_o), 8'h00);
    check("rst valid", 8'(valid_o), 8'h00);
    check("rst overrun", 8'(overrun_o), 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("post-rst early", 8'(valid_o), 8'h00);
    tick(1);
    check("post-rst valid", 8'(valid_o), 8'h01);
    check("post-rst code", 8'(code_o), 8'h01);
    drain();

    // Disabling EI while a key is held reads as a release.
    ready_i = 1'b1;
    I_n = 8'hFB;
    tick(8);
    EI_n = 1'b1;
    tick(3);
    check("dis A_n", 8'(A_n), 8'h07);
    check("dis GS_n", 8'(GS_n), 8'h01);
    check("dis EO_n", 8'(EO_n), 8'h01);
    tick(6);
    ready_i = 1'b0;
    EI_n = 1'b0;
    tick(5);
    check("re-en early", 8'(valid_o), 8'h00);
    tick(1);
    check("re-en valid", 8'(valid_o), 8'h01);
    check("re-en code", 8'(code_o), 8'h02);
    drain();
    I_n = 8'hFF;
    tick(8);
    drain();

`ifdef KEY_ENC_RELEASE_EVT_EN
    ready_i = 1'b1;
    I_n = 8'hEF;
    tick(6);
    check("rel press valid", 8'(valid_o), 8'h01);
    check("rel press code", 8'(code_o), 8'h04);
    check("rel press rel", 8'(rel_o), 8'h00);
    tick(1);
    check("rel press gone", 8'(valid_o), 8'h00);
    I_n = 8'hFF;
    tick(6);
    check("release valid", 8'(valid_o), 8'h01);
    check("release code", 8'(code_o), 8'h04);
    check("release rel", 8'(rel_o), 8'h01);
    tick(1);
    ready_i = 1'b0;
`endif

    // Random phase, checked by the model every cycle.
    for (int n = 0; n < 300; n++) begin
      int kind, hold;
      kind = $urandom_range(0, 9);
      if (kind < 2)      I_n = 8'hFF;
      else if (kind < 6) I_n = ~(8'h01 << $urandom_range(0, 7));
      else if (kind < 8) I_n = ~((8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7)));
      else               I_n = 8'($urandom);
      if ($urandom_range(0, 15) == 0) EI_n = ~EI_n;
      hold = $urandom_range(1, 9);
      for (int h = 0; h < hold; h++) begin
        ready_i = ($urandom_range(0, 3) == 0);
        tick(1);
      end
    end
    ready_i = 1'b0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_encoder83.md
Name: key_encoder83

Overview:
- Sequential 8-to-3 priority encoder. It is the input-side counterpart to the team's 3-8 decoder, for an 8-key active-low keypad.
- Synchronises and debounces eight active-low key lines.
- Presents 74148-style continuous outputs: A_n, GS_n, EO_n.
- Emits one code event per debounced press through a valid/ready handshake to the downstream display/decoder path.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable clocks needed before the sampled key state is accepted (legal range 2..65535).
- CNT_W, $clog2(DEBOUNCE_CYCLES): width of the debounce counter. Derived; must not be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- I_n  in  8  key lines, active low, asynchronous to clk; index 7 has highest priority.
- EI_n  in  1  enable input, active low, asynchronous.
- A_n  out  3  debounced highest-priority key code, inverted (74148 convention).
- GS_n  out  1  low when enabled and at least one debounced key is active.
- EO_n  out  1  low when enabled and no debounced key is active.
- code_o  out  3  event key index, true polarity.
- rel_o  out  1  event is a release; tied 0 unless RELEASE_EVT_EN.
- valid_o  out  1  event pending.
- ready_i  in  1  consumer accepts the event.
- overrun_o  out  1  one-cycle pulse when a pending event is overwritten.

Behaviour:
- Synchronisation: I_n and EI_n each pass through a 2-flop synchroniser. The sync flops reset to all-ones (idle).
- Raw encode, combinational on synced values:
  - any_raw = EI low and any I bit low.
  - code_raw = highest index with a low I bit; 0 if none.
- Debounce:
  - Compare {any_raw, code_raw} with the previous-cycle value. On mismatch, the counter clears to 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES-1.
  - The cycle the counter reaches DEBOUNCE_CYCLES-1, {any_raw, code_raw} loads into the stable register {any_s, code_s}.
  - Latency from a clean input edge to a stable update is 2 + DEBOUNCE_CYCLES clocks.
- Continuous outputs, registered from the stable register:
  - EI disabled (synced EI_n high): A_n=3'b111, GS_n=1, EO_n=1.
  - Enabled, no key: A_n=3'b111, GS_n=1, EO_n=0.
  - Enabled, key active: A_n=~code_s, GS_n=0, EO_n=1.
- Event FSM (states IDLE, HELD):
  - IDLE, and the stable update has any_s becoming 1: raise a press event with code_s, go to HELD.
  - HELD, and the stable update changes code_s while still any: raise a press event with the new code, stay in HELD.
  - HELD, and the stable update has any_s becoming 0: go to IDLE with no event (release event only with the macro).
  - Disabling EI makes any_raw 0. This debounces as a release.
- Handshake, single-entry buffer:
  - Raising an event sets valid_o=1 and loads code_o/rel_o.
  - valid_o && ready_i means the event is consumed; valid_o clears next cycle unless a new event arrives in that same cycle.
  - Same-cycle consume and new event: the new event loads, valid_o stays 1, and there is no overrun.
  - New event while valid_o=1 && !ready_i: code_o/rel_o are overwritten, valid_o stays 1, and overrun_o pulses 1 clock.
  - code_o and rel_o are stable while valid_o=1 && !ready_i, except on overwrite.
- Reset values (asynchronous, immediate):
  - A_n=3'b111, GS_n=1, EO_n=1, code_o=0, rel_o=0, valid_o=0, overrun_o=0.
  - FSM=IDLE, counter=0, stable register = {0,0}.
- Reset mid-operation drops any pending event. After release, a key already held produces a fresh press event after 2 + DEBOUNCE_CYCLES clocks.

Optional Feature:
- Macro KEY_ENC_RELEASE_EVT_EN.
- Defined: HELD to IDLE raises an event with rel_o=1 and code_o = the last held code_s. It obeys the same handshake and overrun rules.
- Undefined: rel_o is tied 0 and no release events are produced.

Decomposition:
- Package key_enc_pkg holds:
  - the state enum key_enc_state_t {IDLE, HELD};
  - localparam KEY_N=8 and KEY_CODE_W=3;
  - the disabled/no-key output constant 3'b111.
- Sub-module key_debounce, parameterised on DEBOUNCE_CYCLES and data width. It contains the counter and the stable register, and outputs the stable data plus a one-cycle update strobe.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then I_n=8'hFF, EI_n=0 -> A_n=111, GS_n=1, EO_n=0, valid_o=0.
- I_n=8'hFB (key 2) held 10 clks, ready_i=0 -> valid_o rises 6 clks after the edge with code_o=2, A_n=101, GS_n=0. valid_o stays high until ready_i=1, then drops next clk.
- I_n=8'h7B (keys 7 and 2) -> press event code_o=7, A_n=000 (priority).
- Bounce on key 2: toggle I_n every 2 clks for 12 clks, then hold low -> no event during the bounce; exactly one event 6 clks after the final edge.
- Key 3 event pending (ready_i=0), then key 5 pressed while key 3 is held -> code_o becomes 5, overrun_o pulses once, valid_o stays 1.
- Key held with event pending, assert rst_n=0 mid-cycle -> all outputs take reset values immediately. After release, a fresh event with code_o of the held key follows 6 clks later.
- Only with KEY_ENC_RELEASE_EVT_EN: press and then release key 4 with ready_i=1 -> two events, (code 4, rel 0) followed by (code 4, rel 1).
